data_memory_sized: RTL and testbench

- Next-generation MIPS data memory: parametrised word width, depth, base address and read latency.
- Adds byte/half/word accesses, with signed or unsigned extension on loads and byte-lane-masked stores.
- Reads are registered and fully pipelined, with a valid strobe.
- Detects misaligned, out-of-range and illegal-size accesses.
- Sits in the MEM stage between the ALU result/store data and the write-back mux.

---
 rtl/data_memory_sized.sv | 208 ++++++++++++++++++++
 tb/tb_data_memory_sized.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_sized.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : data_memory_sized
// Purpose  : MIPS MEM-stage data memory with byte/half/word accesses,
//            signed/unsigned load extension, byte-lane-masked stores, a
//            fully pipelined registered read path and access-error reporting.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DATA_WIDTH   : word width in bits (multiple of 8, >= 16, power-of-two lanes)
//   MEMORY_DEPTH : number of words
//   BASE_ADDRESS : byte address of word 0
//   READ_LATENCY : cycles from the request edge to ReadValid (1..4)
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   Address    in   byte address
//   WriteData  in   store data, right-justified
//   MemWrite   in   store request this cycle
//   MemRead    in   load request this cycle
//   Size       in   00 byte, 01 half, 10 word, 11 illegal
//   Unsigned   in   1 = zero-extend loads, 0 = sign-extend loads
//   ReadData   out  load result, right-justified and extended (0 when invalid)
//   ReadValid  out  ReadData valid this cycle
//   AddrError  out  the access completing this cycle was rejected
// ============================================================================
module data_memory_sized #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned MEMORY_DEPTH = 1024,
  parameter logic [31:0] BASE_ADDRESS = 32'h1001_0000,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           Address,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic                  MemWrite,
  input  logic                  MemRead,
  input  logic [1:0]            Size,
  input  logic                  Unsigned,
  output logic [DATA_WIDTH-1:0] ReadData,
  output logic                  ReadValid,
  output logic                  AddrError
);

  localparam int unsigned NB        = DATA_WIDTH / 8;
  localparam int unsigned LANE_W    = $clog2(NB);
  localparam int unsigned INDEX_W   = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
  localparam bit          WORD_FITS = (DATA_WIDTH >= 32);

  localparam logic [1:0] SIZE_BYTE    = 2'b00;
  localparam logic [1:0] SIZE_HALF    = 2'b01;
  localparam logic [1:0] SIZE_WORD    = 2'b10;
  localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

  // --------------------------------------------------------------------------
  // Address decode
  // --------------------------------------------------------------------------
  logic [31:0]        off;
  logic [31:0]        index;
  logic [LANE_W-1:0]  lane;
  logic [INDEX_W-1:0] word_sel;
  logic               err_range;
  logic               err_size;
  logic               err_align;
  logic               access_err;

  // off wraps for addresses below the base; the explicit compare catches that.
  assign off      = Address - BASE_ADDRESS;
  assign index    = off >> LANE_W;
  assign lane     = off[LANE_W-1:0];
  assign word_sel = index[INDEX_W-1:0];

  assign err_range  = (Address < BASE_ADDRESS) || (index >= 32'(MEMORY_DEPTH));
  assign err_size   = (Size == SIZE_ILLEGAL) || ((Size == SIZE_WORD) && !WORD_FITS);
  assign err_align  = ((Size == SIZE_HALF) && lane[0]) ||
                      ((Size == SIZE_WORD) && (lane != '0));
  assign access_err = err_range || err_size || err_align;

  // --------------------------------------------------------------------------
  // Byte-lane enables and store data alignment
  // --------------------------------------------------------------------------
  logic [2:0]            access_bytes;
  logic [NB-1:0]         size_mask;
  logic [NB-1:0]         lane_en;
  logic [DATA_WIDTH-1:0] write_shifted;
  logic                  write_en;

  always_comb begin
    access_bytes = 3'd4;
    case (Size)
      SIZE_BYTE: access_bytes = 3'd1;
      SIZE_HALF: access_bytes = 3'd2;
      default:   access_bytes = 3'd4;
    endcase
  end

  always_comb begin
    size_mask = '0;
    for (int b = 0; b < int'(NB); b++) begin
      size_mask[b] = (b < int'(access_bytes));
    end
  end

  assign lane_en       = size_mask << lane;
  assign write_shifted = WriteData << {lane, 3'b000};

  // Requests are ignored while reset is held low, including stores.
  assign write_en = MemWrite && !access_err && reset;

  // --------------------------------------------------------------------------
  // Storage array (no reset: contents survive reset)
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem_q [MEMORY_DEPTH];

  always_ff @(posedge clk) begin
    if (write_en) begin
      for (int b = 0; b < int'(NB); b++) begin
        if (lane_en[b]) begin
          mem_q[word_sel][8*b +: 8] <= write_shifted[8*b +: 8];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Load extraction: the array is read combinationally here and captured at
  // the request edge, so a same-cycle store to the word is not yet visible
  // (read-before-write).
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] rd_shifted;
  logic                  sign_bit;
  logic                  fill;
  logic [DATA_WIDTH-1:0] load_ext;
  logic [DATA_WIDTH-1:0] load_value;

  assign rd_word    = mem_q[word_sel];
  assign rd_shifted = rd_word >> {lane, 3'b000};
  assign sign_bit   = (Size == SIZE_BYTE) ? rd_shifted[7] : rd_shifted[15];
  // Word loads always zero-fill above 32 bits; Unsigned only affects byte/half.
  assign fill       = !Unsigned && (Size != SIZE_WORD) && sign_bit;

  always_comb begin
    load_ext = '0;
    for (int i = 0; i < int'(DATA_WIDTH); i++) begin
      load_ext[i] = (i < int'({access_bytes, 3'b000})) ? rd_shifted[i] : fill;
    end
  end

  assign load_value = access_err ? '0 : load_ext;

  // --------------------------------------------------------------------------
  // Read pipeline: stage 0 is loaded at the request edge, the last stage
  // drives the outputs, giving exactly READ_LATENCY cycles of latency.
  // --------------------------------------------------------------------------
  logic [READ_LATENCY-1:0] pipe_valid_d;
  logic [READ_LATENCY-1:0] pipe_valid_q;
  logic [READ_LATENCY-1:0] pipe_err_d;
  logic [READ_LATENCY-1:0] pipe_err_q;
  logic [DATA_WIDTH-1:0]   pipe_data_d [READ_LATENCY];
  logic [DATA_WIDTH-1:0]   pipe_data_q [READ_LATENCY];
  logic                    st_err_d;
  logic                    st_err_q;

  always_comb begin
    pipe_valid_d   = '0;
    pipe_err_d     = '0;
    pipe_data_d    = '{default: '0};
    pipe_valid_d[0] = MemRead;
    pipe_err_d[0]   = MemRead && access_err;
    // Invalid slots carry zero data so ReadData is 0 whenever ReadValid is 0.
    pipe_data_d[0]  = MemRead ? load_value : '0;
    for (int s = 1; s < int'(READ_LATENCY); s++) begin
      pipe_valid_d[s] = pipe_valid_q[s-1];
      pipe_err_d[s]   = pipe_err_q[s-1];
      pipe_data_d[s]  = pipe_data_q[s-1];
    end
  end

  // A rejected store reports for exactly the cycle after its edge.
  assign st_err_d = MemWrite && access_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe_valid_q <= '0;
      pipe_err_q   <= '0;
      for (int s = 0; s < int'(READ_LATENCY); s++) begin
        pipe_data_q[s] <= '0;
      end
      st_err_q <= 1'b0;
    end else begin
      pipe_valid_q <= pipe_valid_d;
      pipe_err_q   <= pipe_err_d;
      for (int s = 0; s < int'(READ_LATENCY); s++) begin
        pipe_data_q[s] <= pipe_data_d[s];
      end
      st_err_q <= st_err_d;
    end
  end

  assign ReadValid = pipe_valid_q[READ_LATENCY-1];
  assign ReadData  = pipe_data_q[READ_LATENCY-1];
  assign AddrError = (pipe_valid_q[READ_LATENCY-1] && pipe_err_q[READ_LATENCY-1]) || st_err_q;

endmodule
`default_nettype wire

// File: tb/tb_data_memory_sized.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_data_memory_sized
// Purpose  : Self-checking bench for data_memory_sized. Two instances share
//            one stimulus stream: READ_LATENCY = 1 and READ_LATENCY = 3.
//            Expected outputs come from a byte-addressed reference memory and
//            a per-cycle schedule of when each response is due.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_memory_sized;

  localparam logic [31:0] BASE  = 32'h1001_0000;
  localparam int          DEPTH = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_write;
  logic        mem_read;
  logic [1:0]  size;
  logic        uns;
  logic [31:0] rdata1, rdata3;
  logic        rv1, rv3, ae1, ae3;

  always #5 clk = ~clk;

  data_memory_sized #(.DATA_WIDTH(32), .MEMORY_DEPTH(DEPTH), .BASE_ADDRESS(BASE), .READ_LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset), .Address(addr), .WriteData(wdata), .MemWrite(mem_write),
    .MemRead(mem_read), .Size(size), .Unsigned(uns),
    .ReadData(rdata1), .ReadValid(rv1), .AddrError(ae1));

  data_memory_sized #(.DATA_WIDTH(32), .MEMORY_DEPTH(DEPTH), .BASE_ADDRESS(BASE), .READ_LATENCY(3)) u_dut3 (
    .clk(clk), .reset(reset), .Address(addr), .WriteData(wdata), .MemWrite(mem_write),
    .MemRead(mem_read), .Size(size), .Unsigned(uns),
    .ReadData(rdata3), .ReadValid(rv3), .AddrError(ae3));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: plain byte array with "has been written" flags.
  logic [7:0] mb [DEPTH*4];
  bit         kn [DEPTH*4];

  typedef struct {
    bit          v;
    bit          e;
    bit          c;   // data is known and can be checked
    logic [31:0] d;
  } ent_t;

  // Responses due after a given edge, indexed by cycle number mod 16.
  ent_t s1 [16];
  ent_t s3 [16];
  bit   serr [16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit acc_err(input logic [31:0] a, input logic [1:0] sz);
    longint o;
    int     nb;
    o  = longint'(a) - longint'(BASE);
    nb = 1 << sz;
    if (sz == 2'b11) return 1'b1;
    if (o < 0) return 1'b1;
    if (o / 4 >= DEPTH) return 1'b1;
    if (o % nb != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(input int o, input logic [1:0] sz, input bit u, output bit known);
    int          nb;
    logic [31:0] v;
    nb    = 1 << sz;
    v     = '0;
    known = 1'b1;
    for (int i = 0; i < nb; i++) begin
      v     = v | (32'(mb[o+i]) << (8*i));
      known = known & kn[o+i];
    end
    if (!u && nb == 1) v = {{24{v[7]}}, v[7:0]};
    if (!u && nb == 2) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  task automatic cmp_out(input string tag, input ent_t e, input bit se,
                         input logic v, input logic [31:0] d, input logic ae);
    check({tag, ".valid"}, 32'(v), 32'(e.v));
    check({tag, ".aerr"}, 32'(ae), 32'((e.v && e.e) || se));
    if (!e.v || e.c) check({tag, ".data"}, d, e.v ? e.d : 32'h0);
  endtask

  task automatic set_idle();
    mem_read  = 1'b0;
    mem_write = 1'b0;
    addr      = BASE;
    wdata     = '0;
    size      = 2'b10;
    uns       = 1'b0;
  endtask

  // One clock cycle: drive request, update model at the edge, check both DUTs.
  task automatic step(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                      input logic [1:0] sz, input bit u, input string tag);
    bit   err;
    int   o;
    int   nb;
    bit   known;
    ent_t e;
    mem_read  = rd;
    mem_write = wr;
    addr      = a;
    wdata     = wd;
    size      = sz;
    uns       = u;
    @(posedge clk);
    err = acc_err(a, sz);
    o   = int'(longint'(a) - longint'(BASE));
    nb  = 1 << sz;
    if (rd) begin
      e.v = 1'b1;
      e.e = err;
      if (err) begin
        e.d = '0;
        e.c = 1'b1;
      end else begin
        e.d = model_load(o, sz, u, known);
        e.c = known;
      end
      s1[cyc % 16]       = e;
      s3[(cyc + 2) % 16] = e;
    end
    if (wr) begin
      if (err) serr[cyc % 16] = 1'b1;
      else begin
        for (int i = 0; i < nb; i++) begin
          mb[o+i] = wd[8*i +: 8];
          kn[o+i] = 1'b1;
        end
      end
    end
    #1;
    cmp_out({tag, ".L1"}, s1[cyc % 16], serr[cyc % 16], rv1, rdata1, ae1);
    cmp_out({tag, ".L3"}, s3[cyc % 16], serr[cyc % 16], rv3, rdata3, ae3);
    s1[cyc % 16]   = '{1'b0, 1'b0, 1'b0, 32'h0};
    s3[cyc % 16]   = '{1'b0, 1'b0, 1'b0, 32'h0};
    serr[cyc % 16] = 1'b0;
    cyc++;
    set_idle();
  endtask

  task automatic sw(input logic [31:0] a, input logic [31:0] d, input string tag);
    step(1'b0, 1'b1, a, d, 2'b10, 1'b0, tag);
  endtask

  task automatic ld(input logic [31:0] a, input logic [1:0] sz, input bit u, input string tag);
    step(1'b1, 1'b0, a, 32'h0, sz, u, tag);
  endtask

  task automatic idle(input string tag);
    step(1'b0, 1'b0, BASE, 32'h0, 2'b10, 1'b0, tag);
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".rv1"}, 32'(rv1), 32'h0);
    check({tag, ".rd1"}, rdata1, 32'h0);
    check({tag, ".ae1"}, 32'(ae1), 32'h0);
    check({tag, ".rv3"}, 32'(rv3), 32'h0);
    check({tag, ".rd3"}, rdata3, 32'h0);
    check({tag, ".ae3"}, 32'(ae3), 32'h0);
  endtask

  logic [31:0] wild [5];
  logic [31:0] ra;
  logic [1:0]  rsz;

  initial begin
    for (int i = 0; i < DEPTH*4; i++) begin
      mb[i] = '0;
      kn[i] = 1'b0;
    end
    for (int i = 0; i < 16; i++) begin
      s1[i]   = '{1'b0, 1'b0, 1'b0, 32'h0};
      s3[i]   = '{1'b0, 1'b0, 1'b0, 32'h0};
      serr[i] = 1'b0;
    end
    wild[0] = BASE - 32'd4;
    wild[1] = BASE + 32'h1000;
    wild[2] = BASE + 32'hFFC;
    wild[3] = 32'h0;
    wild[4] = 32'hFFFF_FFFC;

    // Reset state
    reset = 1'b0;
    set_idle();
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset_state");
    #2 reset = 1'b1;

    // Prefill a window of words plus the last word
    for (int w = 0; w < 16; w++) sw(BASE + 32'(4*w), $urandom, "prefill");
    sw(BASE + 32'hFFC, 32'hC0FF_EE00, "prefill_last");

    // Scenario 1: word store then byte/half loads
    sw(32'h1001_0004, 32'hAABB_CCDD, "s1_sw");
    ld(32'h1001_0004, 2'b00, 1'b0, "s1_lb");
    check("s1_lb_const", rdata1, 32'hFFFF_FFDD);
    ld(32'h1001_0004, 2'b00, 1'b1, "s1_lbu");
    check("s1_lbu_const", rdata1, 32'h0000_00DD);
    ld(32'h1001_0006, 2'b01, 1'b0, "s1_lh");
    check("s1_lh_const", rdata1, 32'hFFFF_AABB);

    // Scenario 2: byte-lane store
    sw(32'h1001_0008, 32'h1111_2222, "s2_neigh");
    step(1'b0, 1'b1, 32'h1001_0005, 32'h1234_567E, 2'b00, 1'b0, "s2_sb");
    ld(32'h1001_0004, 2'b10, 1'b0, "s2_lw");
    check("s2_lw_const", rdata1, 32'hAABB_7EDD);
    ld(32'h1001_0008, 2'b10, 1'b0, "s2_neigh_lw");
    check("s2_neigh_const", rdata1, 32'h1111_2222);

    // Scenario 3: errors
    ld(32'h1001_0002, 2'b10, 1'b0, "s3_misaligned");
    check("s3_mis_ae", 32'(ae1), 32'h1);
    sw(32'h1001_1000, 32'hDEAD_BEEF, "s3_sw_oor");
    check("s3_sw_oor_ae", 32'(ae1), 32'h1);
    ld(32'h1001_0000, 2'b10, 1'b0, "s3_word0");
    ld(32'h1001_0FFC, 2'b10, 1'b0, "s3_last");
    ld(32'h1001_0000, 2'b11, 1'b0, "s3_size11");
    ld(32'h1000_FFFC, 2'b10, 1'b0, "s3_below");
    ld(32'h1001_0001, 2'b01, 1'b1, "s3_half_odd");
    idle("s3_idle");

    // Scenario 4: pipelining
    sw(32'h1001_0010, 32'd1, "s4_sw1");
    sw(32'h1001_0014, 32'd2, "s4_sw2");
    sw(32'h1001_0018, 32'd3, "s4_sw3");
    sw(32'h1001_001C, 32'd4, "s4_sw4");
    ld(32'h1001_0010, 2'b10, 1'b0, "s4_lw1");
    ld(32'h1001_0014, 2'b10, 1'b0, "s4_lw2");
    ld(32'h1001_0018, 2'b10, 1'b0, "s4_lw3");
    check("s4_d1", rdata3, 32'd1);
    ld(32'h1001_001C, 2'b10, 1'b0, "s4_lw4");
    check("s4_d2", rdata3, 32'd2);
    idle("s4_i1");
    check("s4_d3", rdata3, 32'd3);
    idle("s4_i2");
    check("s4_d4", rdata3, 32'd4);
    idle("s4_i3");
    check("s4_gap", rdata3, 32'd0);

    // Scenario 5: simultaneous read and write, same word
    sw(32'h1001_0020, 32'h5, "s5_sw");
    step(1'b1, 1'b1, 32'h1001_0020, 32'h9, 2'b10, 1'b0, "s5_rw");
    check("s5_old", rdata1, 32'h5);
    ld(32'h1001_0020, 2'b10, 1'b0, "s5_lw");
    check("s5_new", rdata1, 32'h9);

    // Scenario 6: reset mid-flight
    ld(32'h1001_0004, 2'b10, 1'b0, "s6_lw");
    idle("s6_i");
    #2 reset = 1'b0;
    #1 check_zero("s6_rst_async");
    for (int i = 0; i < 16; i++) begin
      s1[i]   = '{1'b0, 1'b0, 1'b0, 32'h0};
      s3[i]   = '{1'b0, 1'b0, 1'b0, 32'h0};
      serr[i] = 1'b0;
    end
    // Requests presented during reset must be ignored.
    mem_read  = 1'b1;
    mem_write = 1'b1;
    addr      = 32'h1001_0004;
    wdata     = 32'hDEAD_BEEF;
    size      = 2'b10;
    repeat (2) begin
      @(posedge clk);
      #1 check_zero("s6_rst_hold");
    end
    set_idle();
    #2 reset = 1'b1;
    idle("s6_post");
    ld(32'h1001_0004, 2'b10, 1'b0, "s6_lw_after");
    check("s6_data_kept", rdata1, 32'hAABB_7EDD);
    idle("s6_post2");
    idle("s6_post3");

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) == 0) ra = wild[$urandom_range(0, 4)];
      else ra = BASE + 32'($urandom_range(0, 63));
      rsz = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) ra = ra & ~(32'((1 << rsz) - 1));
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), ra, $urandom,
           rsz, 1'($urandom_range(0, 1)), "rand");
    end
    repeat (4) idle("drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
